// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// States, requester ownership, grant bit positions and word-index helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    localparam logic [63:0] PC_START_DEFAULT = 64'h8000_0000;

    localparam int unsigned GNT_IF  = 0;
    localparam int unsigned GNT_MEM = 1;

    // Byte address to 64-bit word index; wraps modulo 2^64 below the base.
    function automatic logic [63:0] word_idx(input logic [63:0] addr,
                                             input logic [63:0] base);
        return (addr - base) >> 3;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, load/store and RAM-side signals around mem_arbiter.
// slave = arbiter view, master = requesters plus RAM model view.
interface mem_arbiter_if;

    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_req_addr;
    logic        if_resp_valid;
    logic        if_resp_ready;
    logic [63:0] if_resp_data;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [63:0] mem_req_wmask;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [63:0] mem_resp_data;

    logic        ram_en;
    logic [63:0] ram_idx;
    logic [63:0] ram_rdata;
    logic [63:0] ram_wdata;
    logic [63:0] ram_wmask;
    logic        ram_wen;

    modport slave (
        input  if_req_valid, if_req_addr, if_resp_ready,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  mem_resp_ready, ram_rdata,
        output if_req_ready, if_resp_valid, if_resp_data,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        output ram_en, ram_idx, ram_wdata, ram_wmask, ram_wen
    );

    modport master (
        output if_req_valid, if_req_addr, if_resp_ready,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        output mem_resp_ready, ram_rdata,
        input  if_req_ready, if_resp_valid, if_resp_data,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        input  ram_en, ram_idx, ram_wdata, ram_wmask, ram_wen
    );

endinterface

// File: rtl/mem_arbiter_pick.sv
// mem_arb_pick: two-requester arbitration to a one-hot grant.
// prio_i names the requester that wins when both are valid.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       if_valid_i,
    input  logic       mem_valid_i,
    input  owner_e     prio_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = '0;
        if (if_valid_i && mem_valid_i) begin
            if (prio_i == OWN_MEM) grant_o[GNT_MEM] = 1'b1;
            else                   grant_o[GNT_IF]  = 1'b1;
        end else if (mem_valid_i) begin
            grant_o[GNT_MEM] = 1'b1;
        end else if (if_valid_i) begin
            grant_o[GNT_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store: IDLE/ACCESS/RESP.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed mem-over-if.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [63:0] PC_START = PC_START_DEFAULT
)(
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [63:0] addr_q,  addr_d;
    logic        wen_q,   wen_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] wmask_q, wmask_d;
    logic [63:0] rdata_q, rdata_d;

    logic [1:0]  grant;
    owner_e      prio;
    logic        take;

    mem_arb_pick u_pick (
        .if_valid_i  (bus.if_req_valid),
        .mem_valid_i (bus.mem_req_valid),
        .prio_i      (prio),
        .grant_o     (grant)
    );

    // rst_n gates the grant so ready stays low while reset is held.
    assign take = (state_q == ST_IDLE) && rst_n && (grant != 2'b00);

`ifdef ARB_ROUND_ROBIN_EN
    owner_e rr_q, rr_d;

    assign prio = rr_q;

    always_comb begin
        rr_d = rr_q;
        if (take) rr_d = grant[GNT_MEM] ? OWN_IF : OWN_MEM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= OWN_IF;
        else        rr_q <= rr_d;
    end
`else
    assign prio = OWN_MEM;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;

        bus.if_req_ready   = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.if_resp_valid  = 1'b0;
        bus.if_resp_data   = '0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.ram_en         = 1'b0;
        bus.ram_idx        = '0;
        bus.ram_wdata      = '0;
        bus.ram_wmask      = '0;
        bus.ram_wen        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d = ST_ACCESS;
                    if (grant[GNT_MEM]) begin
                        bus.mem_req_ready = 1'b1;
                        owner_d = OWN_MEM;
                        addr_d  = bus.mem_req_addr;
                        wen_d   = bus.mem_req_wen;
                        wdata_d = bus.mem_req_wdata;
                        wmask_d = bus.mem_req_wmask;
                    end else begin
                        bus.if_req_ready = 1'b1;
                        owner_d = OWN_IF;
                        addr_d  = bus.if_req_addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
                end
            end
            ST_ACCESS: begin
                bus.ram_en    = 1'b1;
                bus.ram_idx   = word_idx(addr_q, PC_START);
                bus.ram_wen   = wen_q;
                bus.ram_wdata = wdata_q;
                bus.ram_wmask = wmask_q;
                rdata_d       = wen_q ? '0 : bus.ram_rdata;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                if (owner_q == OWN_IF) begin
                    bus.if_resp_valid = 1'b1;
                    bus.if_resp_data  = rdata_q;
                    if (bus.if_resp_ready) state_d = ST_IDLE;
                end else begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_data  = rdata_q;
                    if (bus.mem_resp_ready) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IF;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
